// File: rtl/clkdiv_pkg.sv
// Shared constants for the programmable clock-enable generator: register map,
// register bit positions, FSM state encoding and the minimum legal divisor.
package clkdiv_pkg;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_DIV     = 2'd1;
   localparam logic [1:0] ADDR_STATUS  = 2'd2;
   localparam logic [1:0] ADDR_TICKCNT = 2'd3;

   localparam int CTRL_EN_BIT      = 0;
   localparam int CTRL_ONESHOT_BIT = 1;
   localparam int CTRL_IRQEN_BIT   = 2;

   localparam int STATUS_RUN_BIT  = 0;
   localparam int STATUS_DONE_BIT = 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   localparam int DIV_MIN = 2;

endpackage

// File: rtl/clkdiv_core.sv
// Period counter with registered tick and square-wave enables. Outputs are
// computed from the next-cycle counter so they line up with the live count.
module clkdiv_core #(
   parameter int DIV_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             run_i,
   input  logic             start_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             tick_o,
   output logic             sq_o
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             sq_q, sq_d;

   // run_i/div_i describe the coming cycle; a registered tick marks the wrap point.
   always_comb begin
      cnt_d = cnt_q + DIV_W'(1);
      if (!run_i || start_i || tick_q) begin
         cnt_d = '0;
      end
      tick_d = run_i && (cnt_d == (div_i - DIV_W'(1)));
      sq_d   = run_i && (cnt_d < (div_i >> 1));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         sq_q   <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         sq_q   <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;

endmodule

// File: rtl/clkdiv_ctrl.sv
// Register block, divisor shadow/reload and run/one-shot FSM around clkdiv_core.
// Define CLKDIV_CTRL_IRQ_EN to build the registered interrupt output and CTRL.irq_en.
module clkdiv_ctrl
   import clkdiv_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter int DIV_RESET = 4,
   parameter int CNT_W     = 32
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cfg_we_i,
   input  logic        cfg_re_i,
   input  logic [1:0]  cfg_addr_i,
   input  logic [31:0] cfg_wdata_i,
   output logic [31:0] cfg_rdata_o,
   output logic        tick_o,
   output logic        sq_out_o,
   output logic        running_o,
   output logic        irq_o
);

   state_e           state_q, state_d;
   logic             enable_q, enable_d;
   logic             oneshot_q, oneshot_d;
   logic             done_q, done_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic [DIV_W-1:0] div_act_q, div_act_d;
   logic [CNT_W-1:0] tickcnt_q, tickcnt_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             running_q;

   logic             ctrl_wr, div_wr, status_wr;
   logic             en_new;
   logic [DIV_W-1:0] wr_div;
   logic             tick_w;
   logic             run_next;
   logic             start_w;
   logic             irq_en_rd;
   logic [31:0]      rd_val;
   logic             unused_wdata;

   assign ctrl_wr   = cfg_we_i && (cfg_addr_i == ADDR_CTRL);
   assign div_wr    = cfg_we_i && (cfg_addr_i == ADDR_DIV);
   assign status_wr = cfg_we_i && (cfg_addr_i == ADDR_STATUS);
   assign wr_div    = cfg_wdata_i[DIV_W-1:0];
   assign unused_wdata = ^cfg_wdata_i;

   always_comb begin
      en_new    = ctrl_wr ? cfg_wdata_i[CTRL_EN_BIT] : enable_q;
      oneshot_d = ctrl_wr ? cfg_wdata_i[CTRL_ONESHOT_BIT] : oneshot_q;

      shadow_d = shadow_q;
      if (div_wr) begin
         shadow_d = (wr_div < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : wr_div;
      end

      state_d  = state_q;
      enable_d = en_new;
      done_d   = done_q;
      if (status_wr && cfg_wdata_i[STATUS_DONE_BIT]) begin
         done_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (en_new) state_d = RUN;
         end
         RUN: begin
            // The one-shot completion outranks a simultaneous disable so done is never lost.
            if (tick_w && oneshot_d) begin
               state_d  = DONE;
               done_d   = 1'b1;
               enable_d = 1'b0;
            end else if (!en_new) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = en_new ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Active divisor only changes outside RUN or on a period boundary.
      div_act_d = (state_q != RUN || tick_w) ? shadow_q : div_act_q;

      tickcnt_d = tickcnt_q;
      if (en_new && !enable_q) begin
         tickcnt_d = '0;
      end else if (tick_w) begin
         tickcnt_d = tickcnt_q + CNT_W'(1);
      end
   end

   assign run_next = (state_d == RUN);
   assign start_w  = (state_q != RUN);

   clkdiv_core #(
      .DIV_W (DIV_W)
   ) u_core (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .run_i   (run_next),
      .start_i (start_w),
      .div_i   (div_act_d),
      .tick_o  (tick_w),
      .sq_o    (sq_out_o)
   );

`ifdef CLKDIV_CTRL_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q, irq_d;

   assign irq_en_d = ctrl_wr ? cfg_wdata_i[CTRL_IRQEN_BIT] : irq_en_q;
   assign irq_d    = done_d & irq_en_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq_en_rd = irq_en_q;
   assign irq_o     = irq_q;
`else
   assign irq_en_rd = 1'b0;
   assign irq_o     = 1'b0;
`endif

   // Reads sample pre-write state, so a same-cycle write is not visible yet.
   always_comb begin
      rd_val = '0;
      case (cfg_addr_i)
         ADDR_CTRL: begin
            rd_val[CTRL_EN_BIT]      = enable_q;
            rd_val[CTRL_ONESHOT_BIT] = oneshot_q;
            rd_val[CTRL_IRQEN_BIT]   = irq_en_rd;
         end
         ADDR_DIV: begin
            rd_val[DIV_W-1:0] = shadow_q;
         end
         ADDR_STATUS: begin
            rd_val[STATUS_RUN_BIT]  = (state_q == RUN);
            rd_val[STATUS_DONE_BIT] = done_q;
         end
         ADDR_TICKCNT: begin
            rd_val = 32'(tickcnt_q);
         end
         default: rd_val = '0;
      endcase
      rdata_d = cfg_re_i ? rd_val : rdata_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         enable_q  <= 1'b0;
         oneshot_q <= 1'b0;
         done_q    <= 1'b0;
         shadow_q  <= DIV_W'(DIV_RESET);
         div_act_q <= DIV_W'(DIV_RESET);
         tickcnt_q <= '0;
         rdata_q   <= '0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         enable_q  <= enable_d;
         oneshot_q <= oneshot_d;
         done_q    <= done_d;
         shadow_q  <= shadow_d;
         div_act_q <= div_act_d;
         tickcnt_q <= tickcnt_d;
         rdata_q   <= rdata_d;
         running_q <= run_next;
      end
   end

   assign cfg_rdata_o = rdata_q;
   assign tick_o      = tick_w;
   assign running_o   = running_q;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Directed bench for clkdiv_ctrl: timing tables for tick/sq_out, register reads,
// one-shot, optional irq (CLKDIV_CTRL_IRQ_EN) and mid-period reset.
module tb_clkdiv_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cfg_we_i = 1'b0;
   logic        cfg_re_i = 1'b0;
   logic [1:0]  cfg_addr_i = 2'd0;
   logic [31:0] cfg_wdata_i = 32'd0;
   logic [31:0] cfg_rdata_o;
   logic        tick_o, sq_out_o, running_o, irq_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [31:0] rd;

`ifdef CLKDIV_CTRL_IRQ_EN
   localparam logic [31:0] EXP_CTRL_RUN  = 32'd7;
   localparam logic [31:0] EXP_CTRL_DONE = 32'd6;
   localparam logic [31:0] EXP_IRQ       = 32'd1;
`else
   localparam logic [31:0] EXP_CTRL_RUN  = 32'd3;
   localparam logic [31:0] EXP_CTRL_DONE = 32'd2;
   localparam logic [31:0] EXP_IRQ       = 32'd0;
`endif

   clkdiv_ctrl #(
      .DIV_W     (16),
      .DIV_RESET (4),
      .CNT_W     (32)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .cfg_we_i    (cfg_we_i),
      .cfg_re_i    (cfg_re_i),
      .cfg_addr_i  (cfg_addr_i),
      .cfg_wdata_i (cfg_wdata_i),
      .cfg_rdata_o (cfg_rdata_o),
      .tick_o      (tick_o),
      .sq_out_o    (sq_out_o),
      .running_o   (running_o),
      .irq_o       (irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
      cfg_addr_i  = addr;
      cfg_wdata_i = data;
      cfg_we_i    = 1'b1;
      step();
      cfg_we_i = 1'b0;
      $display("wr addr=%0d data=0x%08h", addr, data);
   endtask

   task automatic cfg_read(input logic [1:0] addr, output logic [31:0] data);
      cfg_addr_i = addr;
      cfg_re_i   = 1'b1;
      step();
      cfg_re_i = 1'b0;
      data     = cfg_rdata_o;
      $display("rd addr=%0d data=0x%08h", addr, data);
   endtask

   // Entered on a sampled tick cycle; walks one full period of length d.
   task automatic period_check(input string tag, input int d);
      for (int j = 1; j <= d; j++) begin
         step();
         check({tag, "_tick"}, 32'(tick_o), 32'(j == d));
         check({tag, "_sq"}, 32'(sq_out_o), 32'((j - 1) < (d / 2)));
      end
   endtask

   task automatic wait_tick(input string tag, input int bound);
      int n = 0;
      while (tick_o !== 1'b1 && n < bound) begin
         step();
         n++;
      end
      check(tag, 32'(tick_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      check("rst_tick", 32'(tick_o), 32'd0);
      check("rst_sq", 32'(sq_out_o), 32'd0);
      check("rst_running", 32'(running_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_rdata", cfg_rdata_o, 32'd0);
      cfg_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
      cfg_read(2'd1, rd); check("rst_div", rd, 32'd4);
      cfg_read(2'd2, rd); check("rst_status", rd, 32'd0);

      // 1: free-running at the reset divisor
      cfg_write(2'd0, 32'd1);
      check("t1_running", 32'(running_o), 32'd1);
      for (int k = 0; k < 12; k++) begin
         check("t1_tick", 32'(tick_o), 32'((k % 4) == 3));
         check("t1_sq", 32'(sq_out_o), 32'((k % 4) < 2));
         step();
      end
      cfg_read(2'd3, rd); check("t1_tickcnt", rd, 32'd3);

      // 2: divisor change mid-period, counter now at 1
      cfg_write(2'd1, 32'd6);
      check("t2_mid_tick", 32'(tick_o), 32'd0);
      cfg_read(2'd1, rd); check("t2_div_rd", rd, 32'd6);
      check("t2_old_period_tick", 32'(tick_o), 32'd1);
      period_check("t2_p6a", 6);
      period_check("t2_p6b", 6);

      // 3: clamping of 0 and 1
      cfg_write(2'd1, 32'd0);
      cfg_read(2'd1, rd); check("t3_div0", rd, 32'd2);
      cfg_write(2'd1, 32'd1);
      cfg_read(2'd1, rd); check("t3_div1", rd, 32'd2);
      wait_tick("t3_wait", 20);
      period_check("t3_p2a", 2);
      period_check("t3_p2b", 2);

      // 4: one-shot at D=5 (stop on a tick cycle first)
      cfg_write(2'd0, 32'd0);
      check("t4_stop_running", 32'(running_o), 32'd0);
      check("t4_stop_sq", 32'(sq_out_o), 32'd0);
      check("t4_stop_tick", 32'(tick_o), 32'd0);
      cfg_write(2'd1, 32'd5);
      cfg_write(2'd0, 32'd3);
      for (int k = 0; k < 8; k++) begin
         check("t4_tick", 32'(tick_o), 32'(k == 4));
         check("t4_running", 32'(running_o), 32'(k <= 4));
         check("t4_sq", 32'(sq_out_o), 32'(k < 2));
         step();
      end
      cfg_read(2'd2, rd); check("t4_status_done", rd, 32'd2);
      cfg_read(2'd0, rd); check("t4_ctrl", rd, 32'd2);
      cfg_read(2'd3, rd); check("t4_tickcnt", rd, 32'd1);
      cfg_write(2'd2, 32'd2);
      cfg_read(2'd2, rd); check("t4_status_clr", rd, 32'd0);

      // 5: interrupt path with D=3
      cfg_write(2'd1, 32'd3);
      cfg_write(2'd0, 32'd7);
      check("t5_running", 32'(running_o), 32'd1);
      check("t5_irq0", 32'(irq_o), 32'd0);
      cfg_read(2'd0, rd); check("t5_ctrl_run", rd, EXP_CTRL_RUN);
      check("t5_tick_k1", 32'(tick_o), 32'd0);
      step();
      check("t5_tick_k2", 32'(tick_o), 32'd1);
      check("t5_irq_k2", 32'(irq_o), 32'd0);
      step();
      check("t5_irq_k3", 32'(irq_o), EXP_IRQ);
      check("t5_running_k3", 32'(running_o), 32'd0);
      cfg_read(2'd0, rd); check("t5_ctrl_done", rd, EXP_CTRL_DONE);
      cfg_write(2'd2, 32'd2);
      check("t5_irq_clr", 32'(irq_o), 32'd0);
      cfg_read(2'd2, rd); check("t5_status_clr", rd, 32'd0);

      // 6: reset mid-period at counter 2 of D=4
      cfg_write(2'd1, 32'd4);
      cfg_write(2'd0, 32'd1);
      repeat (5) step();
      cfg_read(2'd3, rd); check("t6_tickcnt_pre", rd, 32'd1);
      check("t6_sq_pre", 32'(sq_out_o), 32'd0);
      check("t6_tick_pre", 32'(tick_o), 32'd0);
      rst_ni = 1'b0;
      #2;
      check("t6_rst_running", 32'(running_o), 32'd0);
      check("t6_rst_rdata", cfg_rdata_o, 32'd0);
      check("t6_rst_irq", 32'(irq_o), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("t6_rst_tick", 32'(tick_o), 32'd0);
         check("t6_rst_sq", 32'(sq_out_o), 32'd0);
      end
      rst_ni = 1'b1;
      step();
      check("t6_post_running", 32'(running_o), 32'd0);
      check("t6_post_tick", 32'(tick_o), 32'd0);
      cfg_read(2'd3, rd); check("t6_post_tickcnt", rd, 32'd0);
      cfg_read(2'd2, rd); check("t6_post_status", rd, 32'd0);
      cfg_read(2'd0, rd); check("t6_post_ctrl", rd, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/clkdiv_ctrl.md
Name: clkdiv_ctrl

Overview:
Runtime-programmable clock-enable generator for the RV32I microcontroller's peripheral bus. It replaces fixed-divisor dividers wherever software must change the rate.
- Holds CTRL/DIV/STATUS/TICKCNT registers behind a simple word-addressed config port.
- Sequences a counter that emits a 1-cycle tick enable and a registered square-wave enable.
- Supports free-running and one-shot modes. Divisor changes take effect only at period boundaries, so output stays glitch-free.

Parameters:
DIV_W, 16, width of the divisor register and period counter.
DIV_RESET, 4, divisor value loaded at reset (must be >= 2).
CNT_W, 32, width of the TICKCNT tick counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset: asserted at 0, released synchronously to clk.
cfg_we  input  1  write strobe; one write per cycle.
cfg_re  input  1  read strobe.
cfg_addr  input  2  register select: 0 CTRL, 1 DIV, 2 STATUS, 3 TICKCNT.
cfg_wdata  input  32  write data.
cfg_rdata  output  32  read data, registered.
tick  output  1  1-cycle pulse at the end of each divided period.
sq_out  output  1  registered ~50% duty enable wave.
running  output  1  high while in RUN.
irq  output  1  interrupt, level (optional feature).

Behaviour:
- Reset values: CTRL=0, DIV=DIV_RESET, shadow=DIV_RESET, counter=0, TICKCNT=0, state IDLE, tick=0, sq_out=0, running=0, irq=0, cfg_rdata=0.
- CTRL register: bit0 enable, bit1 oneshot, bit2 irq_en. Upper bits read 0.
- STATUS register: bit0 running (RO), bit1 done (sticky, write-1-to-clear).
- TICKCNT: read-only; increments on every tick; wraps 2^CNT_W-1 -> 0; cleared by enable 0->1.
- DIV writes:
  - Go to the shadow register. Values 0 or 1 are clamped to 2.
  - Shadow is copied to the active divisor in IDLE, or on the tick cycle in RUN.
  - Reading DIV returns the shadow value.
- Reads: cfg_rdata is valid the cycle after cfg_re and holds its value until the next read. Same-cycle read and write to the same address returns the old value.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when enable=1. Counter=0 and active divisor=shadow on entry.
  - RUN: counter counts 0..D-1.
    - tick=1 when counter==D-1; counter wraps to 0.
    - sq_out goes 1 at counter==0 and goes 0 at counter==floor(D/2). For odd D the high phase is the shorter one.
  - RUN -> DONE on a tick when oneshot=1. Sets done; clears enable.
  - RUN -> IDLE when a CTRL write sets enable=0. The counter-generated tick of that cycle still fires; the next cycle has counter=0, sq_out=0, tick=0.
  - DONE -> IDLE the next cycle. DONE also -> RUN if enable is rewritten to 1 in the same cycle.
- A write of enable=1 while already in RUN has no effect on the counter; mode bits update immediately.
- Reset assertion mid-period forces all reset values immediately, with no final tick.
- Arithmetic: counter DIV_W bits, unsigned; the D-1 compare cannot underflow because D >= 2.

Optional Feature:
Macro CLKDIV_CTRL_IRQ_EN.
- Defined: irq = done & irq_en, registered. The irq output is driven from a register, like all other outputs. Clearing done via STATUS write-1 drops irq the next cycle.
- Undefined: irq tied 0, CTRL bit2 is not stored and reads 0, done still functions.

Decomposition:
- Package clkdiv_pkg holds:
  - address localparams ADDR_CTRL/ADDR_DIV/ADDR_STATUS/ADDR_TICKCNT;
  - CTRL/STATUS bit-index localparams;
  - state enum typedef state_e {IDLE, RUN, DONE};
  - DIV_MIN=2.
- One sub-module, clkdiv_core: counter, tick and sq_out generation from active divisor plus a run/clear input.
- clkdiv_ctrl holds the registers, shadow/reload and the FSM.

Test Plan:
1. Reset released, DIV=4 default, write CTRL=1 -> tick every 4 cycles, first tick 4 cycles after entering RUN; sq_out 1,1,0,0 repeating; TICKCNT=3 after 12 cycles.
2. Running at D=4, write DIV=6 mid-period -> current period stays 4 cycles; the next period and onward are 6 cycles; DIV reads 6 immediately.
3. Write DIV=0, then DIV=1 -> DIV reads 2 both times; tick every 2 cycles, sq_out toggles every cycle.
4. CTRL=3 (oneshot) with D=5 -> exactly one tick 5 cycles after start; STATUS=0b10; running=0; writing STATUS=2 clears done.
5. With CLKDIV_CTRL_IRQ_EN defined, CTRL=7 with D=3 -> irq rises 1 cycle after the tick. Without the macro, irq stays 0 and CTRL reads 3.
6. Pull reset low at counter=2 of D=4 -> all outputs 0 with no further tick; after release the block is in IDLE and TICKCNT=0.
